// File: rtl/oled_test_pkg.sv
// Shared types, preset table and lookup helper for the OLED test-pattern source.
package oled_test_pkg;

    typedef enum logic [1:0] {
        ModeManual = 2'd0,
        ModeAuto   = 2'd1,
        ModeSweep  = 2'd2,
        ModeHold   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StShow  = 2'd2
    } state_e;

    localparam int unsigned PresetW     = 20;
    localparam int unsigned PresetDepth = 16;
    localparam int unsigned PresetCh    = 4;

    // Columns: ch0 freq, ch1 amp, ch2 phase, ch3 seg.
    localparam logic [PresetW-1:0] PRESET_TABLE [PresetDepth][PresetCh] = '{
        '{20'd686009, 20'd456,  20'd0,      20'd123456},
        '{20'd686889, 20'd456,  20'd0,      20'd123456},
        '{20'd975633, 20'd600,  20'd100,    20'd6},
        '{20'd999999, 20'd1,    20'd999998, 20'd0},
        '{20'd440000, 20'd512,  20'd90,     20'd4444},
        '{20'd523251, 20'd300,  20'd180,    20'd55555},
        '{20'd659255, 20'd750,  20'd270,    20'd666666},
        '{20'd783991, 20'd1000, 20'd45,     20'd777},
        '{20'd100000, 20'd200,  20'd135,    20'd888888},
        '{20'd250000, 20'd2048, 20'd225,    20'd999},
        '{20'd12345,  20'd4095, 20'd315,    20'd101010},
        '{20'd500000, 20'd128,  20'd30,     20'd111111},
        '{20'd32768,  20'd64,   20'd60,     20'd121212},
        '{20'd65536,  20'd32,   20'd120,    20'd131313},
        '{20'd1000,   20'd16,   20'd240,    20'd141414},
        '{20'd10,     20'd3669, 20'd402,    20'd68231}
    };

    // Narrow index arguments make deeper tables and wider channel counts wrap naturally.
    function automatic logic [PresetW-1:0] preset(input logic [3:0] idx, input logic [1:0] ch);
        return PRESET_TABLE[idx][ch];
    endfunction

endpackage

// File: rtl/oled_dwell_timer.sv
// Dwell counter: counts 0..DWELL_CYC-1, pulses tick at terminal and holds there while blocked.
module oled_dwell_timer #(
    parameter int unsigned DWELL_CYC = 20_000_000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear,
    input  logic enable,
    input  logic pause,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CntW = $clog2(DWELL_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and tick; a reached terminal fires even if paused, once no longer held.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CntLast) begin
                if (!hold) begin
                    tick  = 1'b1;
                    cnt_d = '0;
                end
            end else if (!pause) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_test_pattern_gen.sv
// Test-data source for the OLED/7-segment path: manual, auto-cycle and sweep modes,
// every change delivered through a valid/ready update handshake.
module oled_test_pattern_gen
    import oled_test_pkg::*;
#(
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DWELL_CYC = 20_000_000,
    parameter int unsigned STEP      = 1,
    parameter int unsigned MAX_VAL   = 999_999,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [1:0]               mode_in,
    input  logic [IDX_W-1:0]         key_data,
    input  logic                     key_valid,
    input  logic                     pause_in,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [IDX_W-1:0]         index_out,
    output logic                     upd_valid,
    input  logic                     upd_ready
);

    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]         index_q, index_d;
    state_e                   state_q, state_d;
    logic [1:0]               mode_q;
    logic                     pend_q, pend_d;
    logic [IDX_W-1:0]         pend_idx_q, pend_idx_d;

    mode_e              mode_cur;
    logic               mode_change;
    logic               blocked;
    logic               tick;
    logic               timer_en;
    logic               load_manual;
    logic               load;
    logic [IDX_W-1:0]   man_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [3:0]         sel_idx4;
    logic [NUM_CH*DATA_W-1:0] preset_vec;
    logic [NUM_CH*DATA_W-1:0] sweep_vec;

    assign mode_cur    = mode_e'(mode_in);
    assign mode_change = (mode_in != mode_q);
    assign upd_valid   = (state_q == StIssue);
    assign blocked     = upd_valid && !upd_ready;
    assign timer_en    = !mode_change && (mode_cur == ModeAuto || mode_cur == ModeSweep);

    oled_dwell_timer #(
        .DWELL_CYC (DWELL_CYC)
    ) u_dwell_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear    (mode_change),
        .enable   (timer_en),
        .pause    (pause_in),
        .hold     (blocked),
        .tick     (tick)
    );

    assign next_idx = (index_q == IDX_W'(DEPTH - 1)) ? '0 : index_q + IDX_W'(1);
    assign sel_idx  = load_manual ? man_idx : next_idx;
    assign sel_idx4 = 4'(sel_idx);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W:0] sum;
        assign sum = {1'b0, data_q[c*DATA_W +: DATA_W]} + (DATA_W + 1)'(STEP);
        assign sweep_vec[c*DATA_W +: DATA_W] =
            (sum <= (DATA_W + 1)'(MAX_VAL)) ? sum[DATA_W-1:0] : '0;
        assign preset_vec[c*DATA_W +: DATA_W] = DATA_W'(preset(sel_idx4, 2'(c)));
    end

    // Manual key handling: load now if unblocked, else park it (latest key wins).
    always_comb begin
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        load_manual = 1'b0;
        man_idx     = pend_idx_q;
        if (mode_change) begin
            pend_d = 1'b0;
        end
        if (mode_cur == ModeManual) begin
            if (key_valid) begin
                if (blocked) begin
                    pend_d     = 1'b1;
                    pend_idx_d = key_data;
                end else begin
                    load_manual = 1'b1;
                    man_idx     = key_data;
                    pend_d      = 1'b0;
                end
            end else if (pend_q && !blocked && !mode_change) begin
                load_manual = 1'b1;
                pend_d      = 1'b0;
            end
        end
    end

    // Output data/index next values and handshake state machine.
    always_comb begin
        data_d  = data_q;
        index_d = index_q;
        load    = 1'b0;
        state_d = state_q;
        if (load_manual) begin
            load    = 1'b1;
            index_d = man_idx;
            data_d  = preset_vec;
        end else if (tick && mode_cur == ModeAuto) begin
            load    = 1'b1;
            index_d = next_idx;
            data_d  = preset_vec;
        end else if (tick && mode_cur == ModeSweep) begin
            load    = 1'b1;
            data_d  = sweep_vec;
        end
        case (state_q)
            StIdle:  if (load) state_d = StIssue;
            StIssue: begin
                if (load) begin
                    state_d = StIssue;
                end else if (upd_ready) begin
                    state_d = StShow;
                end
            end
            StShow:  if (load) state_d = StIssue;
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q     <= '0;
            index_q    <= '0;
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            data_q     <= data_d;
            index_q    <= index_d;
            state_q    <= state_d;
            mode_q     <= mode_in;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign data_out  = data_q;
    assign index_out = index_q;

endmodule
